matrix_pointwise_mac_nxn: RTL and testbench

//  Parametrised Winograd-domain element-wise multiply-accumulate over an N x N tile.

---
 rtl/matrix_pointwise_mac_nxn.sv | 131 +++++++++++++
 tb/tb_matrix_pointwise_mac_nxn.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_pointwise_mac_nxn.sv
`default_nettype none
// ============================================================================
// Module      : matrix_pointwise_mac_nxn
// Description : N x N element-wise multiply-accumulate over framed runs of
//               beats (Winograd-domain MAC), valid/ready with backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_pointwise_mac_nxn #(
   parameter int N          = 6,
   parameter int DATA_W     = 16,
   parameter int ACC_W      = 40,
   parameter int MUL_STAGES = 2
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic                               in_first,
   input  logic                               in_last,
   input  logic                               signed_mode,
   input  logic [N-1:0][N-1:0][DATA_W-1:0]    a,
   input  logic [N-1:0][N-1:0][DATA_W-1:0]    b,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [N-1:0][N-1:0][ACC_W-1:0]     c
);

   localparam int c_PROD_W = 2 * DATA_W;
   localparam int c_LAST   = MUL_STAGES - 1;
   // Upper ACC_W bits above the product; empty when ACC_W equals the product width.
   localparam logic [ACC_W-1:0] c_EXT_MASK = ~((ACC_W'(1) << c_PROD_W) - ACC_W'(1));

   typedef logic [N-1:0][N-1:0][c_PROD_W-1:0] prod_tile_t;
   typedef logic [N-1:0][N-1:0][ACC_W-1:0]    acc_tile_t;

   logic                  w_en;
   prod_tile_t            w_prod;
   acc_tile_t             w_ext;
   acc_tile_t             w_acc_next;
   logic                  w_start;
   logic                  w_load;

   logic [MUL_STAGES-1:0] r_pv;
   logic [MUL_STAGES-1:0] r_pfirst;
   logic [MUL_STAGES-1:0] r_plast;
   logic [MUL_STAGES-1:0] r_psigned;
   prod_tile_t            r_prod [MUL_STAGES];

   acc_tile_t             r_acc;
   logic                  r_acc_open;
   acc_tile_t             r_c;
   logic                  r_out_valid;

   assign w_en      = !r_out_valid || out_ready;
   assign in_ready  = w_en;
   assign out_valid = r_out_valid;
   assign c         = r_c;

   // Operands widened to the product width so the low half of the product is
   // exact for both two's complement and unsigned interpretation.
   always_comb begin
      w_prod = '0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            w_prod[i][j] = {{DATA_W{signed_mode & a[i][j][DATA_W-1]}}, a[i][j]} *
                           {{DATA_W{signed_mode & b[i][j][DATA_W-1]}}, b[i][j]};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pv      <= '0;
         r_pfirst  <= '0;
         r_plast   <= '0;
         r_psigned <= '0;
         for (int s = 0; s < MUL_STAGES; s++) begin
            r_prod[s] <= '0;
         end
      end else if (w_en) begin
         r_pv[0]      <= in_valid;
         r_pfirst[0]  <= in_first;
         r_plast[0]   <= in_last;
         r_psigned[0] <= signed_mode;
         r_prod[0]    <= w_prod;
         for (int s = 1; s < MUL_STAGES; s++) begin
            r_pv[s]      <= r_pv[s-1];
            r_pfirst[s]  <= r_pfirst[s-1];
            r_plast[s]   <= r_plast[s-1];
            r_psigned[s] <= r_psigned[s-1];
            r_prod[s]    <= r_prod[s-1];
         end
      end
   end

   assign w_start = r_pfirst[c_LAST] || !r_acc_open;
   assign w_load  = r_pv[c_LAST] && r_plast[c_LAST];

   always_comb begin
      w_ext      = '0;
      w_acc_next = '0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            w_ext[i][j] = ACC_W'(r_prod[c_LAST][i][j]) |
                          ((r_psigned[c_LAST] && r_prod[c_LAST][i][j][c_PROD_W-1]) ? c_EXT_MASK : '0);
            w_acc_next[i][j] = w_start ? w_ext[i][j] : r_acc[i][j] + w_ext[i][j];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc       <= '0;
         r_acc_open  <= 1'b0;
         r_c         <= '0;
         r_out_valid <= 1'b0;
      end else if (w_en) begin
         if (r_pv[c_LAST]) begin
            r_acc      <= w_acc_next;
            r_acc_open <= !r_plast[c_LAST];
         end
         // With en high any held result is being consumed, so valid follows the load.
         r_out_valid <= w_load;
         if (w_load) begin
            r_c <= w_acc_next;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_matrix_pointwise_mac_nxn.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_pointwise_mac_nxn
// Description : Directed self-checking bench with a run-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_pointwise_mac_nxn;

   typedef logic [5:0][5:0][15:0] dtile_t;
   typedef logic [5:0][5:0][39:0] ctile_t;

   logic   clk = 1'b0;
   logic   rst_n;
   logic   in_valid, in_ready, in_first, in_last, signed_mode;
   dtile_t a, b;
   logic   out_valid, out_ready;
   ctile_t c;

   logic                    v2, rdy2, f2, l2, s2, ov2, or2;
   logic [1:0][1:0][15:0]   a2, b2;
   logic [1:0][1:0][31:0]   c2;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   matrix_pointwise_mac_nxn #(.N(6), .DATA_W(16), .ACC_W(40), .MUL_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_first(in_first), .in_last(in_last), .signed_mode(signed_mode),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .c(c));

   matrix_pointwise_mac_nxn #(.N(2), .DATA_W(16), .ACC_W(32), .MUL_STAGES(2)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2),
      .in_first(f2), .in_last(l2), .signed_mode(s2),
      .a(a2), .b(b2), .out_valid(ov2), .out_ready(or2), .c(c2));

   function automatic dtile_t fill(input logic [15:0] v);
      dtile_t t;
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 6; j++)
            t[i][j] = v;
      return t;
   endfunction

   function automatic logic [63:0] prod(input logic [15:0] x, input logic [15:0] y, input bit s);
      longint r;
      if (s) r = longint'($signed(x)) * longint'($signed(y));
      else   r = longint'(x) * longint'(y);
      return r;
   endfunction

   function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endfunction

   // Reference model: sums whole runs at acceptance time, queues finished tiles.
   ctile_t q[$];
   ctile_t m_sum;
   bit     m_open;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_open = 1'b0;
         m_sum  = '0;
      end else begin
         if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
         if (in_valid && in_ready) begin
            for (int i = 0; i < 6; i++) begin
               for (int j = 0; j < 6; j++) begin
                  logic [63:0] p;
                  p = prod(a[i][j], b[i][j], signed_mode);
                  if (in_first || !m_open) m_sum[i][j] = p[39:0];
                  else                     m_sum[i][j] = m_sum[i][j] + p[39:0];
               end
            end
            if (in_last) begin
               q.push_back(m_sum);
               m_open = 1'b0;
            end else begin
               m_open = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin : cmp
      bit bad;
      int bi, bj;
      if (rst_n && out_valid) begin
         vectors++;
         if (q.size() == 0) begin
            miscompares++;
            $display("FAIL spurious_out: out_valid=1 with no expected result, c[0][0]=0x%0h", c[0][0]);
         end else begin
            bad = 1'b0; bi = 0; bj = 0;
            for (int i = 0; i < 6; i++)
               for (int j = 0; j < 6; j++)
                  if (!bad && c[i][j] !== q[0][i][j]) begin
                     bad = 1'b1; bi = i; bj = j;
                  end
            if (bad) begin
               miscompares++;
               $display("FAIL model_tile: c[%0d][%0d] got 0x%0h expected 0x%0h",
                        bi, bj, c[bi][bj], q[0][bi][bj]);
            end
         end
      end
   end

   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic send(input dtile_t ta, input dtile_t tb, input bit f, input bit l, input bit s);
      bit ok;
      int k;
      a = ta; b = tb; in_first = f; in_last = l; signed_mode = s; in_valid = 1'b1;
      k = 0;
      while (1) begin
         #1 ok = in_ready;
         @(negedge clk);
         if (ok) break;
         k++;
         if (k > 100) begin
            check("send_timeout", 64'd0, 64'd1);
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output ctile_t t);
      int k;
      k = 0;
      while (!out_valid && k < 40) begin
         @(negedge clk);
         k++;
      end
      if (!out_valid) check("wait_out_timeout", 64'd0, 64'd1);
      t = c;
      @(negedge clk);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ctile_t t;
      dtile_t ta, tb;
      rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; signed_mode = 1'b0;
      a = '0; b = '0; out_ready = 1'b1;
      v2 = 1'b0; f2 = 1'b0; l2 = 1'b0; s2 = 1'b0; a2 = '0; b2 = '0; or2 = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_out_valid", {63'd0, out_valid}, 64'd0);
      check("reset_in_ready", {63'd0, in_ready}, 64'd1);
      check("reset_c", {24'd0, c[5][5]}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single unsigned beat, latency of three edges
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 6; j++) begin
            ta[i][j] = 16'(i + 1);
            tb[i][j] = 16'(j + 2);
         end
      send(ta, tb, 1'b1, 1'b1, 1'b0);
      check("t1_valid_cyc1", {63'd0, out_valid}, 64'd0);
      @(negedge clk);
      check("t1_valid_cyc2", {63'd0, out_valid}, 64'd0);
      @(negedge clk);
      check("t1_valid_cyc3", {63'd0, out_valid}, 64'd1);
      check("t1_c55", {24'd0, c[5][5]}, 64'd42);
      check("t1_c00", {24'd0, c[0][0]}, 64'd2);
      check("t1_c23", {24'd0, c[2][3]}, 64'd15);
      @(negedge clk);

      // Four signed beats with a bubble inside the run
      send(fill(16'hFFFD), fill(16'd7), 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      send(fill(16'hFFFD), fill(16'd7), 1'b0, 1'b0, 1'b1);
      send(fill(16'hFFFD), fill(16'd7), 1'b0, 1'b0, 1'b1);
      send(fill(16'hFFFD), fill(16'd7), 1'b0, 1'b1, 1'b1);
      wait_out(t);
      check("t2_c00", {24'd0, t[0][0]}, 64'h00_0000_FF_FFFF_FFAC);
      check("t2_c52", {24'd0, t[5][2]}, 64'h00_0000_FF_FFFF_FFAC);

      // Unsigned then signed beat in one run
      send(fill(16'hFFFF), fill(16'd2), 1'b1, 1'b0, 1'b0);
      send(fill(16'hFFFF), fill(16'd2), 1'b0, 1'b1, 1'b1);
      wait_out(t);
      check("t4_mixed", {24'd0, t[3][3]}, 64'd131068);

      // in_first inside an open run discards the partial sum
      send(fill(16'd10), fill(16'd10), 1'b1, 1'b0, 1'b0);
      send(fill(16'd2),  fill(16'd2),  1'b1, 1'b0, 1'b0);
      send(fill(16'd3),  fill(16'd3),  1'b0, 1'b1, 1'b0);
      wait_out(t);
      check("restart_mid_run", {24'd0, t[1][4]}, 64'd13);

      // Backpressure while three two-beat runs stream in
      fork
         begin
            send(fill(16'd1), fill(16'd1), 1'b1, 1'b0, 1'b0);
            send(fill(16'd1), fill(16'd2), 1'b0, 1'b1, 1'b0);
            send(fill(16'd2), fill(16'd2), 1'b1, 1'b0, 1'b0);
            send(fill(16'd1), fill(16'd1), 1'b0, 1'b1, 1'b0);
            send(fill(16'd3), fill(16'd3), 1'b1, 1'b0, 1'b0);
            send(fill(16'd1), fill(16'd3), 1'b0, 1'b1, 1'b0);
         end
         begin
            out_ready = 1'b0;
            repeat (5) @(negedge clk);
            #1;
            check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
            check("bp_c_run1", {24'd0, c[1][1]}, 64'd3);
            @(negedge clk);
            out_ready = 1'b1;
         end
      join
      repeat (12) @(negedge clk);
      check("bp_all_drained", 64'(q.size()), 64'd0);

      // Reset in the middle of a run, then a standalone beat
      send(fill(16'd5), fill(16'd5), 1'b1, 1'b0, 1'b0);
      send(fill(16'd5), fill(16'd5), 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      check("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_mid_c", {24'd0, c[1][1]}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(fill(16'd3), fill(16'd3), 1'b1, 1'b1, 1'b0);
      wait_out(t);
      check("rst_then_9", {24'd0, t[4][4]}, 64'd9);

      // Same again, but the post-reset beat carries no in_first
      send(fill(16'd5), fill(16'd5), 1'b1, 1'b0, 1'b0);
      send(fill(16'd5), fill(16'd5), 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(fill(16'd3), fill(16'd3), 1'b0, 1'b1, 1'b0);
      wait_out(t);
      check("rst_nofirst_9", {24'd0, t[0][5]}, 64'd9);

      // Accumulator wrap at ACC_W = 32
      a2 = {4{16'hFFFF}}; b2 = {4{16'hFFFF}};
      v2 = 1'b1; f2 = 1'b1; l2 = 1'b0; s2 = 1'b0;
      @(negedge clk);
      f2 = 1'b0; l2 = 1'b1;
      @(negedge clk);
      v2 = 1'b0;
      begin
         int k;
         k = 0;
         while (!ov2 && k < 20) begin
            @(negedge clk);
            k++;
         end
      end
      check("wrap_valid", {63'd0, ov2}, 64'd1);
      check("wrap_c11", {32'd0, c2[1][1]}, 64'hFFFC_0002);
      @(negedge clk);

      check("model_queue_empty", 64'(q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
